// File: rtl/reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_bus_arbiter
// Purpose  : Shares one register-bus slave port between NM requesters using
//            round-robin arbitration with a single outstanding transaction.
//            The winner's command is latched onto the m* bus, held until the
//            slave returns sready, then read data / error response are handed
//            back to the winner with a one-cycle ack pulse and priority
//            rotates to the requester after the winner.
// Ports    : hclk, hresetn      - clock, asynchronous active-low reset
//            req/rwrite         - per-requester request and write flag (NM)
//            raddr/rstrb/rwdata - per-requester command, slice i at [i*W +: W]
//            ack                - one-hot completion pulse (NM)
//            rrdata/rresp       - read data / error, valid with ack, then held
//            busy               - arbiter not idle
//            mreq/mwrite/maddr/mstrb/mdata - command to the shared slave
//            sdata/sready/sresp - slave response
// Option   : REG_ARB_TIMEOUT_EN - when defined, a transaction that sees no
//            sready for TO_CYC BUS cycles completes with rresp=1, rrdata=0.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bus_arbiter #(
    parameter int NM     = 2,
    parameter int DW     = 32,
    parameter int AW     = 32,
    parameter int WW     = 4,
    parameter int TO_CYC = 255
) (
    input  logic             hclk,
    input  logic             hresetn,
    input  logic [NM-1:0]    req,
    input  logic [NM-1:0]    rwrite,
    input  logic [NM*AW-1:0] raddr,
    input  logic [NM*WW-1:0] rstrb,
    input  logic [NM*DW-1:0] rwdata,
    output logic [NM-1:0]    ack,
    output logic [DW-1:0]    rrdata,
    output logic             rresp,
    output logic             busy,
    output logic             mreq,
    output logic             mwrite,
    output logic [AW-1:0]    maddr,
    output logic [WW-1:0]    mstrb,
    output logic [DW-1:0]    mdata,
    input  logic [DW-1:0]    sdata,
    input  logic             sready,
    input  logic             sresp
);

    localparam int IW = (NM > 1) ? $clog2(NM) : 1;

    if (NM < 2 || NM > 8 || TO_CYC < 1) begin : g_param_check
        $error("reg_bus_arbiter: NM must be 2..8 and TO_CYC must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [IW-1:0]   r_ptr, w_ptr_nxt;
    logic [IW-1:0]   r_win, w_win_nxt;
    logic [NM-1:0]   r_ack, w_ack_nxt;
    logic [DW-1:0]   r_rrdata, w_rrdata_nxt;
    logic            r_rresp, w_rresp_nxt;
    logic            r_mreq, w_mreq_nxt;
    logic            r_mwrite, w_mwrite_nxt;
    logic [AW-1:0]   r_maddr, w_maddr_nxt;
    logic [WW-1:0]   r_mstrb, w_mstrb_nxt;
    logic [DW-1:0]   r_mdata, w_mdata_nxt;

    logic            w_found;
    logic [IW-1:0]   w_pick;

`ifdef REG_ARB_TIMEOUT_EN
    localparam int c_cnt_w = ($clog2(TO_CYC + 1) > 8) ? $clog2(TO_CYC + 1) : 8;
    // The counter is compared one below the limit so that the transition to
    // DONE happens on the edge where the count would reach TO_CYC.
    localparam logic [c_cnt_w-1:0] c_to_last = c_cnt_w'(TO_CYC - 1);
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
`endif

    // Round-robin pick: first requesting index scanning upward from r_ptr,
    // wrapping modulo NM (NM need not be a power of two).
    always_comb begin : p_pick
        int j;
        w_found = 1'b0;
        w_pick  = '0;
        j       = 0;
        for (int i = 0; i < NM; i++) begin
            j = int'(r_ptr) + i;
            if (j >= NM) begin
                j = j - NM;
            end
            if (!w_found && req[j]) begin
                w_found = 1'b1;
                w_pick  = IW'(j);
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin : p_next
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_win_nxt    = r_win;
        w_ack_nxt    = r_ack;
        w_rrdata_nxt = r_rrdata;
        w_rresp_nxt  = r_rresp;
        w_mreq_nxt   = r_mreq;
        w_mwrite_nxt = r_mwrite;
        w_maddr_nxt  = r_maddr;
        w_mstrb_nxt  = r_mstrb;
        w_mdata_nxt  = r_mdata;
`ifdef REG_ARB_TIMEOUT_EN
        w_cnt_nxt    = r_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_win_nxt    = w_pick;
                    w_mwrite_nxt = rwrite[w_pick];
                    w_maddr_nxt  = raddr[int'(w_pick)*AW +: AW];
                    w_mstrb_nxt  = rstrb[int'(w_pick)*WW +: WW];
                    w_mdata_nxt  = rwdata[int'(w_pick)*DW +: DW];
                    w_mreq_nxt   = 1'b1;
                    w_state_nxt  = S_BUS;
`ifdef REG_ARB_TIMEOUT_EN
                    w_cnt_nxt    = '0;
`endif
                end
            end
            S_BUS: begin
                if (sready) begin
                    w_mreq_nxt       = 1'b0;
                    w_rrdata_nxt     = r_mwrite ? '0 : sdata;
                    w_rresp_nxt      = sresp;
                    w_ack_nxt        = '0;
                    w_ack_nxt[r_win] = 1'b1;
                    w_state_nxt      = S_DONE;
                end
`ifdef REG_ARB_TIMEOUT_EN
                else if (r_cnt == c_to_last) begin
                    w_mreq_nxt       = 1'b0;
                    w_rrdata_nxt     = '0;
                    w_rresp_nxt      = 1'b1;
                    w_ack_nxt        = '0;
                    w_ack_nxt[r_win] = 1'b1;
                    w_cnt_nxt        = r_cnt + 1'b1;
                    w_state_nxt      = S_DONE;
                end else begin
                    w_cnt_nxt        = r_cnt + 1'b1;
                end
`endif
            end
            S_DONE: begin
                // req is deliberately ignored here so the acked requester
                // has one cycle to drop its request.
                w_ack_nxt   = '0;
                w_ptr_nxt   = (r_win == IW'(NM - 1)) ? '0 : r_win + 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_win    <= '0;
            r_ack    <= '0;
            r_rrdata <= '0;
            r_rresp  <= 1'b0;
            r_mreq   <= 1'b0;
            r_mwrite <= 1'b0;
            r_maddr  <= '0;
            r_mstrb  <= '0;
            r_mdata  <= '0;
`ifdef REG_ARB_TIMEOUT_EN
            r_cnt    <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_win    <= w_win_nxt;
            r_ack    <= w_ack_nxt;
            r_rrdata <= w_rrdata_nxt;
            r_rresp  <= w_rresp_nxt;
            r_mreq   <= w_mreq_nxt;
            r_mwrite <= w_mwrite_nxt;
            r_maddr  <= w_maddr_nxt;
            r_mstrb  <= w_mstrb_nxt;
            r_mdata  <= w_mdata_nxt;
`ifdef REG_ARB_TIMEOUT_EN
            r_cnt    <= w_cnt_nxt;
`endif
        end
    end

    assign ack    = r_ack;
    assign rrdata = r_rrdata;
    assign rresp  = r_rresp;
    assign busy   = (r_state != S_IDLE);
    assign mreq   = r_mreq;
    assign mwrite = r_mwrite;
    assign maddr  = r_maddr;
    assign mstrb  = r_mstrb;
    assign mdata  = r_mdata;

endmodule
`default_nettype wire

// File: doc/reg_bus_arbiter.md
Name: reg_bus_arbiter

Overview:
- Shares one register-bus slave port between NM requesters; the port is mreq/mwrite/maddr/mstrb/mdata out and sdata/sready/sresp back.
- Each requester is typically an ahb-to-register bridge or an internal config engine.
- Round-robin arbitration with a single outstanding transaction: latch the winner's command, drive the bus until sready, return read data and response to the winner, then rotate priority.
- Sits between the requester bridges and the shared register file / peripheral register decode.

Parameters:
- NM, 2, number of requesters (2..8)
- DW, 32, data width
- AW, 32, address width
- WW, 4, byte-strobe width
- TO_CYC, 255, timeout in cycles; used only when REG_ARB_TIMEOUT_EN is defined

Ports:
- hclk  in  1  clock
- hresetn  in  1  asynchronous active-low reset
- req  in  NM  per-requester request; held high until that requester's ack
- rwrite  in  NM  per-requester write (1) / read (0)
- raddr  in  NM*AW  per-requester address; slice i = bits [i*AW +: AW]
- rstrb  in  NM*WW  per-requester byte strobes
- rwdata  in  NM*DW  per-requester write data
- ack  out  NM  one-hot, one-cycle completion pulse to the winner
- rrdata  out  DW  read data; valid while ack is high
- rresp  out  1  error response; valid while ack is high
- busy  out  1  high whenever state is not IDLE
- mreq  out  1  bus request to the slave
- mwrite  out  1  bus write
- maddr  out  AW  bus address
- mstrb  out  WW  bus strobes
- mdata  out  DW  bus write data
- sdata  in  DW  slave read data
- sready  in  1  slave done; sampled while mreq=1
- sresp  in  1  slave error; sampled with sready

Behaviour:
- Reset (hresetn=0, asynchronous):
  - state=IDLE, pointer ptr=0.
  - All outputs 0: ack, rrdata, rresp, busy, mreq, mwrite, maddr, mstrb, mdata.
- FSM states IDLE, BUS, DONE.
- IDLE:
  - If req!=0, pick the winner: the first set bit scanning from ptr upward, wrapping modulo NM.
  - Register winner index, rwrite/raddr/rstrb/rwdata slices into mwrite/maddr/mstrb/mdata; mreq<=1; go to BUS.
  - If req==0, stay in IDLE.
- BUS:
  - mreq held at 1; m* outputs stable.
  - On sready=1: mreq<=0; rrdata<=sdata when read, 0 when write; rresp<=sresp; ack[winner]<=1; go to DONE.
- DONE (exactly one cycle):
  - ack pulse active.
  - ptr<=(winner+1) mod NM.
  - req is ignored this cycle, so the acked requester has one cycle to drop req.
  - Go to IDLE; ack<=0.
- Latency:
  - req rising at edge 0 gives mreq=1 after edge 1.
  - sready=1 at the first BUS cycle gives ack=1 after edge 2.
  - Minimum 3 cycles per transaction; back-to-back grants to different requesters every 3 cycles.
- A requester that drops req while its transaction is in BUS does not abort it; the transaction completes and ack still pulses.
- req for the current winner re-asserted after DONE is treated as a new request, arbitrated normally.
- Simultaneous requests: exactly one winner; losers wait with req high and no ack.
- Fairness: with all NM requesting, each is served once every NM transactions.
- ack is one-hot or zero, never multi-hot. rrdata/rresp hold their value after the ack cycle until the next completion.
- m* outputs hold the last command after completion; only mreq qualifies them.
- Asynchronous reset mid-BUS: mreq drops immediately; no ack is issued.

Optional Feature:
- Macro REG_ARB_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to BUS and increments each BUS cycle with sready=0.
  - When count reaches TO_CYC, go to DONE with mreq<=0, rresp<=1, rrdata<=0, and ack to the winner. A stuck slave therefore never locks the bus.
  - sready arriving in the same cycle the count reaches TO_CYC wins: normal completion.
- Undefined: no counter; BUS waits indefinitely for sready.

Test Plan:
- Single read: req=2'b01, rwrite=0, raddr[0]=0x40, sready=1 with sdata=0xDEADBEEF on the first BUS cycle -> mreq high for 1 cycle with maddr=0x40 and mwrite=0; ack=2'b01 after edge 2; rrdata=0xDEADBEEF, rresp=0.
- Write with wait states: req[1]=1, rwrite[1]=1, rwdata=0x1234, rstrb=4'b0011; sready held low 4 cycles -> mreq/mdata/mstrb stable 5 cycles; ack=2'b10; rrdata=0.
- Contention: both req held high for 4 transactions, ptr starts at 0 -> grant order 0,1,0,1; each ack 3 cycles apart when sready=1 immediately.
- Error: sresp=1 with sready -> rresp=1 on the ack cycle; next transaction rresp=0.
- Reset mid-BUS: hresetn low while mreq=1 -> mreq=0 asynchronously, ack never pulses, ptr=0 afterwards.
- REG_ARB_TIMEOUT_EN with TO_CYC=8 and sready held low -> ack after 8 BUS cycles, rresp=1, rrdata=0; bus then serves the other requester.
